// File: rtl/wb_unit_pkg.sv
// Shared widths, source encoding and queue entry layout for the writeback collector.
package wb_unit_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WADDR_W = 32;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic src_e src_other(input src_e s);
        return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_unit_if.sv
// Result handshakes, regfile write port and pending-write query of the writeback collector.
interface wb_unit_if;
    import wb_unit_pkg::*;

    logic                 alu_valid_in;
    logic                 alu_ready_out;
    logic [REG_AW-1:0]    alu_addr_in;
    logic [DATA_W-1:0]    alu_data_in;
    logic                 lsu_valid_in;
    logic                 lsu_ready_out;
    logic [REG_AW-1:0]    lsu_addr_in;
    logic [DATA_W-1:0]    lsu_data_in;
    logic                 we_out;
    logic [WADDR_W-1:0]   w_addr_out;
    logic [DATA_W-1:0]    w_data_out;
    logic [REG_AW-1:0]    q_addr_in;
    logic                 q_pending_out;
    logic                 busy_out;

    modport master (
        output alu_valid_in, alu_addr_in, alu_data_in,
        output lsu_valid_in, lsu_addr_in, lsu_data_in,
        output q_addr_in,
        input  alu_ready_out, lsu_ready_out,
        input  we_out, w_addr_out, w_data_out,
        input  q_pending_out, busy_out
    );

    modport slave (
        input  alu_valid_in, alu_addr_in, alu_data_in,
        input  lsu_valid_in, lsu_addr_in, lsu_data_in,
        input  q_addr_in,
        output alu_ready_out, lsu_ready_out,
        output we_out, w_addr_out, w_data_out,
        output q_pending_out, busy_out
    );

endinterface

// File: rtl/wb_unit_fifo.sv
// Per-source result FIFO with extra-MSB pointers and per-slot valid/addr taps for the query.
module wb_fifo
    import wb_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk_in,
    input  logic                          rstn_in,
    input  logic                          push_in,
    input  wb_entry_t                     push_entry_in,
    input  logic                          pop_in,
    output wb_entry_t                     head_out,
    output logic                          full_out,
    output logic                          empty_out,
    output logic [DEPTH-1:0]              tap_vld_out,
    output logic [DEPTH-1:0][REG_AW-1:0]  tap_addr_out
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] tap_off [DEPTH];
    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];

    assign head_out  = mem_q[rd_q[IDX_W-1:0]];
    assign empty_out = (wr_q == rd_q);
    assign full_out  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                       (wr_q[IDX_W-1:0] == rd_q[IDX_W-1:0]);
    assign count     = wr_q - rd_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push_in) begin
            mem_d[wr_q[IDX_W-1:0]] = push_entry_in;
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop_in) begin
            rd_d = rd_q + PTR_W'(1);
        end
    end

    // A slot is live when its distance from the read index is below the occupancy.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            tap_off[i]      = IDX_W'(i) - rd_q[IDX_W-1:0];
            tap_vld_out[i]  = ({1'b0, tap_off[i]} < count);
            tap_addr_out[i] = mem_q[i].addr;
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback collector: two result FIFOs, round-robin arbiter and registered regfile write port.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic       rdy_in,
    wb_unit_if.slave   bus
);

    logic                          alu_full, alu_empty, alu_push, alu_pop;
    logic                          lsu_full, lsu_empty, lsu_push, lsu_pop;
    wb_entry_t                     alu_head, lsu_head;
    logic [DEPTH-1:0]              alu_tap_vld, lsu_tap_vld;
    logic [DEPTH-1:0][REG_AW-1:0]  alu_tap_addr, lsu_tap_addr;

    src_e               rr_q, rr_d;
    logic               we_q, we_d;
    logic [REG_AW-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               q_hit;

    assign bus.alu_ready_out = rstn_in & rdy_in & ~alu_full;
    assign bus.lsu_ready_out = rstn_in & rdy_in & ~lsu_full;

    // x0 results complete the handshake but never enter a FIFO.
    assign alu_push = bus.alu_valid_in & bus.alu_ready_out & (bus.alu_addr_in != '0);
    assign lsu_push = bus.lsu_valid_in & bus.lsu_ready_out & (bus.lsu_addr_in != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .push_in       (alu_push),
        .push_entry_in ('{addr: bus.alu_addr_in, data: bus.alu_data_in}),
        .pop_in        (alu_pop),
        .head_out      (alu_head),
        .full_out      (alu_full),
        .empty_out     (alu_empty),
        .tap_vld_out   (alu_tap_vld),
        .tap_addr_out  (alu_tap_addr)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .push_in       (lsu_push),
        .push_entry_in ('{addr: bus.lsu_addr_in, data: bus.lsu_data_in}),
        .pop_in        (lsu_pop),
        .head_out      (lsu_head),
        .full_out      (lsu_full),
        .empty_out     (lsu_empty),
        .tap_vld_out   (lsu_tap_vld),
        .tap_addr_out  (lsu_tap_addr)
    );

    always_comb begin
        alu_pop = 1'b0;
        lsu_pop = 1'b0;
        rr_d    = rr_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (rdy_in) begin
            we_d = 1'b0;
            // rr_q only advances when both sources compete.
            if (!alu_empty && !lsu_empty) begin
                if (rr_q == SRC_ALU) alu_pop = 1'b1;
                else                 lsu_pop = 1'b1;
                rr_d = src_other(rr_q);
            end else if (!alu_empty) begin
                alu_pop = 1'b1;
            end else if (!lsu_empty) begin
                lsu_pop = 1'b1;
            end
            if (alu_pop) begin
                we_d    = 1'b1;
                waddr_d = alu_head.addr;
                wdata_d = alu_head.data;
            end else if (lsu_pop) begin
                we_d    = 1'b1;
                waddr_d = lsu_head.addr;
                wdata_d = lsu_head.data;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            rr_q    <= SRC_ALU;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        q_hit = we_q && (waddr_q == bus.q_addr_in);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_tap_vld[i] && (alu_tap_addr[i] == bus.q_addr_in)) q_hit = 1'b1;
            if (lsu_tap_vld[i] && (lsu_tap_addr[i] == bus.q_addr_in)) q_hit = 1'b1;
        end
    end

    assign bus.q_pending_out = (bus.q_addr_in != '0) && q_hit;
    assign bus.busy_out      = ~alu_empty | ~lsu_empty | we_q;
    assign bus.we_out        = we_q;
    assign bus.w_addr_out    = {{(WADDR_W-REG_AW){1'b0}}, waddr_q};
    assign bus.w_data_out    = wdata_q;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed vector table, directed corner sequences, and random traffic vs a queue model.
module tb_wb_unit;

    localparam int unsigned DEPTH = 4;

    logic clk_in  = 1'b0;
    logic rstn_in = 1'b0;
    logic rdy_in  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    wb_unit_if bus();

    wb_unit #(.DEPTH(DEPTH)) dut (
        .clk_in  (clk_in),
        .rstn_in (rstn_in),
        .rdy_in  (rdy_in),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit rdy; bit av; logic [4:0] aa; logic [31:0] ad;
        bit lv; logic [4:0] la; logic [31:0] ld; logic [4:0] qa;
        bit e_we; logic [31:0] e_wa; logic [31:0] e_wd;
        bit e_ar; bit e_lr; bit e_busy; bit e_qp;
    } vec_t;

    // Reference model: one queue per source plus the visible write port.
    ent_t        mq_alu[$];
    ent_t        mq_lsu[$];
    bit          m_rr_lsu;
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_alu.delete();
        mq_lsu.delete();
        m_rr_lsu = 1'b0;
        m_we     = 1'b0;
        m_wa     = '0;
        m_wd     = '0;
    endtask

    function automatic bit m_pending(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq_alu[i]) if (mq_alu[i].addr == q) return 1'b1;
        foreach (mq_lsu[i]) if (mq_lsu[i].addr == q) return 1'b1;
        return m_we && (m_wa == q);
    endfunction

    task automatic drive(input bit rdy, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld, input logic [4:0] qa);
        rdy_in           = rdy;
        bus.alu_valid_in = av;
        bus.alu_addr_in  = aa;
        bus.alu_data_in  = ad;
        bus.lsu_valid_in = lv;
        bus.lsu_addr_in  = la;
        bus.lsu_data_in  = ld;
        bus.q_addr_in    = qa;
    endtask

    // One clock of lockstep checking; entered and left on a falling edge.
    task automatic cycle(input bit rdy, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld, input logic [4:0] qa,
                         output bit a_acc, output bit l_acc, output bit ar_seen);
        bit   exp_ar, exp_lr, take_a, take_l;
        ent_t e;
        drive(rdy, av, aa, ad, lv, la, ld, qa);
        #1;
        exp_ar = rdy && (mq_alu.size() < DEPTH);
        exp_lr = rdy && (mq_lsu.size() < DEPTH);
        ar_seen = bus.alu_ready_out;
        chk("alu_ready", {31'd0, bus.alu_ready_out}, {31'd0, exp_ar});
        chk("lsu_ready", {31'd0, bus.lsu_ready_out}, {31'd0, exp_lr});
        chk("q_pending", {31'd0, bus.q_pending_out}, {31'd0, m_pending(qa)});
        chk("busy", {31'd0, bus.busy_out},
            {31'd0, (mq_alu.size() > 0) || (mq_lsu.size() > 0) || m_we});
        a_acc = av && exp_ar;
        l_acc = lv && exp_lr;
        if (rdy) begin
            take_a = 1'b0;
            take_l = 1'b0;
            if (mq_alu.size() > 0 && mq_lsu.size() > 0) begin
                if (m_rr_lsu) take_l = 1'b1; else take_a = 1'b1;
                m_rr_lsu = !m_rr_lsu;
            end else if (mq_alu.size() > 0) take_a = 1'b1;
            else if (mq_lsu.size() > 0)     take_l = 1'b1;
            m_we = take_a || take_l;
            if (take_a) begin e = mq_alu.pop_front(); m_wa = e.addr; m_wd = e.data; end
            if (take_l) begin e = mq_lsu.pop_front(); m_wa = e.addr; m_wd = e.data; end
            if (a_acc && aa != 5'd0) mq_alu.push_back('{aa, ad});
            if (l_acc && la != 5'd0) mq_lsu.push_back('{la, ld});
        end
        @(posedge clk_in);
        @(negedge clk_in);
        chk("we", {31'd0, bus.we_out}, {31'd0, m_we});
        if (m_we) begin
            chk("w_addr", bus.w_addr_out, {27'd0, m_wa});
            chk("w_data", bus.w_data_out, m_wd);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rstn_in = 1'b0;
        drive(1'b1, 0, '0, '0, 0, '0, '0, '0);
        repeat (2) @(negedge clk_in);
        rstn_in = 1'b1;
        model_reset();
    endtask

    vec_t        tbl[11];
    bit          aacc, lacc, ar;
    int          ka, kl;
    bit          saw_full;
    logic [31:0] alu_acc_list[$];
    logic [31:0] alu_wr_list[$];
    bit          pa_v, pl_v;
    logic [4:0]  pa_a, pl_a;
    logic [31:0] pa_d, pl_d;

    initial begin
        //          rdy av aa     ad             lv la     ld            qa    we wa      wd             ar lr bs qp
        tbl[0]  = '{1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,      5'd5, 0, 32'd0, 32'h0,      1, 1, 1, 1};
        tbl[1]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      5'd5, 1, 32'd5, 32'hDEADBEEF, 1, 1, 1, 1};
        tbl[2]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      5'd5, 0, 32'd0, 32'h0,      1, 1, 0, 0};
        tbl[3]  = '{1, 0, 5'd0, 32'h0,        1, 5'd0, 32'h1234,   5'd0, 0, 32'd0, 32'h0,      1, 1, 0, 0};
        tbl[4]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      5'd0, 0, 32'd0, 32'h0,      1, 1, 0, 0};
        tbl[5]  = '{1, 1, 5'd1, 32'h000000A1, 1, 5'd2, 32'h000000B1, 5'd1, 0, 32'd0, 32'h0,    1, 1, 1, 1};
        tbl[6]  = '{1, 1, 5'd3, 32'h000000A2, 1, 5'd4, 32'h000000B2, 5'd2, 1, 32'd1, 32'hA1,   1, 1, 1, 1};
        tbl[7]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      5'd3, 1, 32'd2, 32'hB1,     1, 1, 1, 1};
        tbl[8]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      5'd2, 1, 32'd3, 32'hA2,     1, 1, 1, 0};
        tbl[9]  = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      5'd4, 1, 32'd4, 32'hB2,     1, 1, 1, 1};
        tbl[10] = '{1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,      5'd4, 0, 32'd0, 32'h0,      1, 1, 0, 0};

        drive(1'b1, 0, '0, '0, 0, '0, '0, '0);
        #1;
        chk("rst_we", {31'd0, bus.we_out}, 32'd0);
        chk("rst_alu_ready", {31'd0, bus.alu_ready_out}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy_out}, 32'd0);
        do_reset();

        // Single write, x0 drop, and contention ordering A1,L1,A2,L2.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rdy, tbl[i].av, tbl[i].aa, tbl[i].ad,
                  tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].qa);
            @(posedge clk_in);
            @(negedge clk_in);
            chk($sformatf("tbl%0d_we", i), {31'd0, bus.we_out}, {31'd0, tbl[i].e_we});
            if (tbl[i].e_we) begin
                chk($sformatf("tbl%0d_waddr", i), bus.w_addr_out, tbl[i].e_wa);
                chk($sformatf("tbl%0d_wdata", i), bus.w_data_out, tbl[i].e_wd);
            end
            chk($sformatf("tbl%0d_alu_ready", i), {31'd0, bus.alu_ready_out}, {31'd0, tbl[i].e_ar});
            chk($sformatf("tbl%0d_lsu_ready", i), {31'd0, bus.lsu_ready_out}, {31'd0, tbl[i].e_lr});
            chk($sformatf("tbl%0d_busy", i), {31'd0, bus.busy_out}, {31'd0, tbl[i].e_busy});
            chk($sformatf("tbl%0d_qpend", i), {31'd0, bus.q_pending_out}, {31'd0, tbl[i].e_qp});
        end

        // Stall with a write on the port and r7 still queued.
        do_reset();
        cycle(1, 1, 5'd6, 32'h66, 0, '0, '0, 5'd7, aacc, lacc, ar);
        cycle(1, 1, 5'd7, 32'h77, 0, '0, '0, 5'd7, aacc, lacc, ar);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, '0, 0, '0, '0, 5'd7, aacc, lacc, ar);
            chk("stall_we", {31'd0, bus.we_out}, 32'd1);
            chk("stall_addr", bus.w_addr_out, 32'd6);
            chk("stall_qpend7", {31'd0, bus.q_pending_out}, 32'd1);
        end
        cycle(1, 0, '0, '0, 0, '0, '0, 5'd7, aacc, lacc, ar);
        chk("drain_addr7", bus.w_addr_out, 32'd7);
        cycle(1, 0, '0, '0, 0, '0, '0, 5'd7, aacc, lacc, ar);
        #1;
        chk("drain_qpend7", {31'd0, bus.q_pending_out}, 32'd0);
        @(negedge clk_in);

        // ALU flood against a competing LSU flood until ALU backs up.
        do_reset();
        ka = 0; kl = 0; saw_full = 0;
        for (int c = 0; c < 60 && !(saw_full && alu_acc_list.size() >= DEPTH + 1); c++) begin
            cycle(1, 1, 5'(1 + ka % 31), 32'h1000 + ka, 1, 5'(1 + (kl + 7) % 31), 32'h8000_0000 + kl,
                  5'd0, aacc, lacc, ar);
            if (!ar) saw_full = 1;
            if (aacc) begin alu_acc_list.push_back(32'h1000 + ka); ka++; end
            if (lacc) kl++;
            if (bus.we_out && !bus.w_data_out[31]) alu_wr_list.push_back(bus.w_data_out);
        end
        for (int c = 0; c < 4 * DEPTH; c++) begin
            cycle(1, 0, '0, '0, 0, '0, '0, '0, aacc, lacc, ar);
            if (bus.we_out && !bus.w_data_out[31]) alu_wr_list.push_back(bus.w_data_out);
        end
        chk("full_ready_low_seen", {31'd0, saw_full}, 32'd1);
        chk("full_alu_count", alu_wr_list.size(), alu_acc_list.size());
        for (int i = 0; i < alu_acc_list.size() && i < alu_wr_list.size(); i++)
            chk($sformatf("full_alu_order%0d", i), alu_wr_list[i], alu_acc_list[i]);

        // Reset mid-stream with several ALU results queued.
        do_reset();
        ka = 0; kl = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(1, 1, 5'(1 + ka % 31), 32'h2000 + ka, 1, 5'(1 + (kl + 7) % 31), 32'h8000_0000 + kl,
                  5'd0, aacc, lacc, ar);
            if (aacc) ka++;
            if (lacc) kl++;
        end
        chk("pre_reset_queued", {31'd0, mq_alu.size() >= 3}, 32'd1);
        bus.q_addr_in = mq_alu[0].addr;
        rstn_in = 1'b0;
        #1;
        chk("midrst_we", {31'd0, bus.we_out}, 32'd0);
        chk("midrst_waddr", bus.w_addr_out, 32'd0);
        chk("midrst_wdata", bus.w_data_out, 32'd0);
        chk("midrst_alu_ready", {31'd0, bus.alu_ready_out}, 32'd0);
        chk("midrst_lsu_ready", {31'd0, bus.lsu_ready_out}, 32'd0);
        chk("midrst_qpend", {31'd0, bus.q_pending_out}, 32'd0);
        @(negedge clk_in);
        drive(1'b1, 0, '0, '0, 0, '0, '0, bus.q_addr_in);
        @(negedge clk_in);
        rstn_in = 1'b1;
        model_reset();
        #1;
        chk("postrst_busy", {31'd0, bus.busy_out}, 32'd0);
        chk("postrst_alu_ready", {31'd0, bus.alu_ready_out}, 32'd1);
        @(negedge clk_in);
        for (int c = 0; c < 2; c++) cycle(1, 0, '0, '0, 0, '0, '0, '0, aacc, lacc, ar);

        // Random traffic; producers hold a payload until it is accepted.
        do_reset();
        pa_v = 0; pl_v = 0; pa_a = '0; pl_a = '0; pa_d = '0; pl_d = '0;
        for (int c = 0; c < 500; c++) begin
            if (!pa_v && $urandom_range(0, 9) < 6) begin
                pa_v = 1; pa_a = 5'($urandom_range(0, 7)); pa_d = $urandom;
            end
            if (!pl_v && $urandom_range(0, 9) < 6) begin
                pl_v = 1; pl_a = 5'($urandom_range(0, 7)); pl_d = $urandom;
            end
            cycle($urandom_range(0, 9) < 8, pa_v, pa_a, pa_d, pl_v, pl_a, pl_d,
                  5'($urandom_range(0, 7)), aacc, lacc, ar);
            if (aacc) pa_v = 0;
            if (lacc) pl_v = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
